// File: rtl/display_decoder.sv
// Recovers minutes/seconds from an active-low multiplexed 7-segment scan bus.
// Optional DISP_DEC_SYNC_EN adds a two-flop synchronizer ahead of the sample stage.
module display_decoder #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned BLANK_TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg,
  input  logic [3:0] an,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       frame_valid,
  output logic       seg_error,
  output logic       blanked
);

  localparam int          BW          = $clog2(BLANK_TIMEOUT + 1);
  localparam int unsigned SETTLE_M1   = SETTLE_CYCLES - 1;
  localparam logic [7:0]  SETTLE_MAX  = SETTLE_CYCLES[7:0];
  localparam logic [7:0]  SETTLE_LAST = SETTLE_M1[7:0];
  localparam logic [BW-1:0] BLANK_MAX = BLANK_TIMEOUT[BW-1:0];
  localparam logic [10:0] SCAN_IDLE   = 11'h7FF;

  logic [10:0] pin_scan;
  logic [10:0] scan_in;

  assign pin_scan = {an, seg};

`ifdef DISP_DEC_SYNC_EN
  logic [10:0] sync1_q, sync1_d;
  logic [10:0] sync2_q, sync2_d;

  assign sync1_d = pin_scan;
  assign sync2_d = sync1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= SCAN_IDLE;
      sync2_q <= SCAN_IDLE;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign scan_in = sync2_q;
`else
  assign scan_in = pin_scan;
`endif

  // Returns {valid, digit} for an active-low {g..a} pattern.
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b1000000: r = {1'b1, 4'd0};
      7'b1111001: r = {1'b1, 4'd1};
      7'b0100100: r = {1'b1, 4'd2};
      7'b0110000: r = {1'b1, 4'd3};
      7'b0011001: r = {1'b1, 4'd4};
      7'b0010010: r = {1'b1, 4'd5};
      7'b0000010: r = {1'b1, 4'd6};
      7'b1111000: r = {1'b1, 4'd7};
      7'b0000000: r = {1'b1, 4'd8};
      7'b0010000: r = {1'b1, 4'd9};
      default:    r = {1'b0, 4'd0};
    endcase
    return r;
  endfunction

  logic [10:0]     scan_q, scan_d;
  logic [7:0]      settle_cnt_q, settle_cnt_d;
  logic [BW-1:0]   blank_cnt_q, blank_cnt_d;
  logic [3:0]      mask_q, mask_d;
  logic [3:0][3:0] digit_q, digit_d;
  logic            eval_q, eval_d;
  logic [5:0]      minutes_q, minutes_d;
  logic [5:0]      seconds_q, seconds_d;
  logic            frame_valid_q, frame_valid_d;
  logic            seg_error_q, seg_error_d;
  logic            blanked_q, blanked_d;

  logic       stable;
  logic       capture;
  logic       one_hot;
  logic       all_off;
  logic [1:0] slot;
  logic [4:0] dec;

  always_comb begin
    scan_d        = scan_in;
    settle_cnt_d  = settle_cnt_q;
    blank_cnt_d   = blank_cnt_q;
    mask_d        = mask_q;
    digit_d       = digit_q;
    eval_d        = 1'b0;
    minutes_d     = minutes_q;
    seconds_d     = seconds_q;
    frame_valid_d = 1'b0;
    seg_error_d   = 1'b0;
    blanked_d     = blanked_q;
    one_hot       = 1'b0;
    all_off       = 1'b0;
    slot          = 2'd0;
    dec           = seg_decode(scan_q[6:0]);

    // Stability compares the value entering S with the value already held.
    stable = (scan_in == scan_q);
    if (!stable) begin
      settle_cnt_d = 8'd0;
    end else if (settle_cnt_q != SETTLE_MAX) begin
      settle_cnt_d = settle_cnt_q + 8'd1;
    end
    capture = stable && (settle_cnt_q == SETTLE_LAST);

    if (scan_q[10:7] == 4'hF) begin
      if (blank_cnt_q != BLANK_MAX) begin
        blank_cnt_d = blank_cnt_q + BW'(1);
      end
    end else begin
      blank_cnt_d = '0;
    end

    case (scan_q[10:7])
      4'b1110: begin one_hot = 1'b1; slot = 2'd0; end
      4'b1101: begin one_hot = 1'b1; slot = 2'd1; end
      4'b1011: begin one_hot = 1'b1; slot = 2'd2; end
      4'b0111: begin one_hot = 1'b1; slot = 2'd3; end
      4'b1111: all_off = 1'b1;
      default: ;
    endcase

    if (eval_q) begin
      mask_d = 4'h0;
      if ((digit_q[3] <= 4'd5) && (digit_q[1] <= 4'd5)) begin
        minutes_d     = 6'(digit_q[3]) * 6'd10 + 6'(digit_q[2]);
        seconds_d     = 6'(digit_q[1]) * 6'd10 + 6'(digit_q[0]);
        frame_valid_d = 1'b1;
      end else begin
        seg_error_d = 1'b1;
      end
    end else if (capture) begin
      if (one_hot) begin
        if (dec[4]) begin
          digit_d[slot] = dec[3:0];
          mask_d[slot]  = 1'b1;
          blanked_d     = 1'b0;
          eval_d        = (mask_d == 4'hF);
        end else begin
          mask_d[slot] = 1'b0;
          seg_error_d  = 1'b1;
        end
      end else if (!all_off) begin
        seg_error_d = 1'b1;
      end
    end

    // A long blank discards any partially collected frame.
    if (blank_cnt_d == BLANK_MAX) begin
      blanked_d = 1'b1;
      mask_d    = 4'h0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_q        <= SCAN_IDLE;
      settle_cnt_q  <= 8'd0;
      blank_cnt_q   <= '0;
      mask_q        <= 4'h0;
      digit_q       <= '0;
      eval_q        <= 1'b0;
      minutes_q     <= 6'd0;
      seconds_q     <= 6'd0;
      frame_valid_q <= 1'b0;
      seg_error_q   <= 1'b0;
      blanked_q     <= 1'b0;
    end else begin
      scan_q        <= scan_d;
      settle_cnt_q  <= settle_cnt_d;
      blank_cnt_q   <= blank_cnt_d;
      mask_q        <= mask_d;
      digit_q       <= digit_d;
      eval_q        <= eval_d;
      minutes_q     <= minutes_d;
      seconds_q     <= seconds_d;
      frame_valid_q <= frame_valid_d;
      seg_error_q   <= seg_error_d;
      blanked_q     <= blanked_d;
    end
  end

  assign minutes     = minutes_q;
  assign seconds     = seconds_q;
  assign frame_valid = frame_valid_q;
  assign seg_error   = seg_error_q;
  assign blanked     = blanked_q;

endmodule
